seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits.
REQ-002 SHALL have parameter SYNC, default 4'b1101: 4-bit frame header, sent MSB first.
REQ-003 SHALL have parameter IDLE_BIT, default 1'b0: line level when no frame is in flight.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port data_in, input, DATA_W: payload word offered for transmission.
REQ-007 SHALL have port data_valid, input, 1: data_in holds a word to send.
REQ-008 SHALL have port data_ready, output, 1: block accepts a word this cycle.
REQ-009 SHALL have port dout, output, 1: registered serial line, one bit per clk cycle.
REQ-010 SHALL have port dout_en, output, 1: high while dout carries a frame bit.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse marking the last bit of a frame.

Function
REQ-012 SHALL send each frame as SYNC[3:0], then data MSB first, then one even-parity bit over the payload: 4+DATA_W+1 bits, 13 at default.
REQ-013 SHALL use FSM states IDLE, SYNC, DATA, PARITY: IDLE->SYNC on handshake; SYNC->DATA after 4 bits; DATA->PARITY after DATA_W bits; PARITY->SYNC on handshake, else ->IDLE.
REQ-014 SHALL treat a handshake as data_valid and data_ready both high at a rising edge; data_in SHALL be captured into the shift register on that edge only.
REQ-015 SHALL drive data_ready combinationally high in IDLE and in PARITY; low in SYNC and DATA.
REQ-016 SHALL present SYNC[3] on dout in the cycle immediately after the handshake edge: latency one clk.
REQ-017 SHALL, on a handshake during PARITY, start the next frame's SYNC[3] in the next cycle, with no idle gap.
REQ-018 SHALL ignore changes on data_in after capture, and data_valid while data_ready is low.
REQ-019 SHALL hold dout=IDLE_BIT and dout_en=0 in IDLE.
REQ-020 SHALL assert frame_done exactly in the cycle dout carries the parity bit.
REQ-021 SHALL keep a bit counter sized for max(4, DATA_W) that resets to 0 on every state change; no wrap-around inside a state.
REQ-022 SHALL change dout only on rising edges, so a falling-edge serial sampler has half a cycle of setup.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-frame, immediately abort the frame: state IDLE, counter 0, shift register 0, dout=IDLE_BIT, dout_en=0, frame_done=0.
REQ-024 SHALL hold data_ready low while rst is high; it goes high in the first cycle after release.
REQ-025 SHALL NOT resume an aborted frame after reset.

Structure
REQ-026 SHALL place the state enum, SYNC default, sync length 4 and the frame-length function in shared package seq_pkg.
REQ-027 SHALL split the datapath into one sub-module seq_tx_shreg (load, shift, running parity); the FSM stays in seq_tx.

Verification
REQ-028 SHALL cover single frame: data 0xA5 -> dout 1101_10100101_0; dout_en high 13 cycles; frame_done pulses once on bit 13.
REQ-029 SHALL cover back-to-back: 0x00 then 0xFF, data_valid held -> 1101_00000000_0_1101_11111111_0 with no gap; data_ready high only in the two parity cycles plus the initial IDLE.
REQ-030 SHALL cover parity: data 0x01 -> parity bit 1; data 0x03 -> parity bit 0.
REQ-031 SHALL cover reset mid-frame: rst pulsed during payload bit 3 of 0xA5 -> dout=0 and dout_en=0 asynchronously; next handshake 0x3C -> clean 1101_00111100_0.
REQ-032 SHALL cover loopback: dout feeds the team's falling-edge 1101/0110 detector, payload 0x00 after at least 4 idle cycles -> detector flag pulses exactly twice per frame, after sync bits 3 and 4.
REQ-033 SHALL cover stall: data_valid toggled while data_ready is low -> no capture and the frame bit sequence is unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the seq_tx serial frame transmitter.
//   seq_state_t  - transmitter FSM state encoding
//   SYNC_DEFAULT - default 4-bit frame header
//   SYNC_LEN     - header length in bits
//   frame_len()  - total frame length for a given payload width
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } seq_state_t;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // header + payload + one parity bit
  function automatic int frame_len(input int data_w);
    return SYNC_LEN + data_w + 1;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: payload shift register with running even parity.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (clears word and parity)
//   i_load   - capture i_data, clear running parity
//   i_shift  - shift word left by one, fold outgoing MSB into parity
//   i_data   - payload word to capture
//   o_msb    - bit that will go out on the next shift
//   o_parity - XOR of all bits shifted out since the last load
module seq_tx_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_msb,
  output logic              o_parity
);

  logic [DATA_W-1:0] r_word;
  logic              r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_par  <= 1'b0;
    end else if (i_load) begin
      r_word <= i_data;
      r_par  <= 1'b0;
    end else if (i_shift) begin
      r_word <= r_word << 1;
      r_par  <= r_par ^ r_word[DATA_W-1];
    end
  end

  assign o_msb    = r_word[DATA_W-1];
  assign o_parity = r_par;

endmodule

// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter. Each accepted word goes out as
// SYNC[3:0], payload MSB first, then an even-parity bit, one bit per clk.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset, aborts any frame in flight
//   data_in    - payload word offered for transmission
//   data_valid - data_in holds a word to send
//   data_ready - block accepts a word this cycle (IDLE or PARITY)
//   dout       - registered serial line
//   dout_en    - high while dout carries a frame bit
//   frame_done - one-cycle pulse coincident with the parity bit
//
// state     | meaning
// ST_IDLE   | line idle, ready for a word
// ST_SYNC   | sending header bits, r_cnt = header bit index
// ST_DATA   | sending payload bits, r_cnt = payload bit index
// ST_PARITY | sending parity bit, ready for the next word
module seq_tx
  import seq_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] SYNC     = SYNC_DEFAULT,
  parameter logic       IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_done
);

  localparam int CNT_MAX = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_dout_en;
  logic             r_done;

  logic w_ready;
  logic w_hs;
  logic w_shift;
  logic w_msb;
  logic w_par;
  logic w_sync_next;

  // Ready is forced low during reset so no handshake can be seen then.
  assign w_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_PARITY));
  assign w_hs    = w_ready && data_valid;

  // A payload bit leaves the shift register on every edge that puts one on
  // dout: the SYNC->DATA edge and every DATA edge except the last.
  assign w_shift = ((r_state == ST_SYNC) && (r_cnt == SYNC_LAST)) ||
                   ((r_state == ST_DATA) && (r_cnt != DATA_LAST));

  // next header bit while walking SYNC[3] down to SYNC[0]
  assign w_sync_next = SYNC[2'd2 - r_cnt[1:0]];

  seq_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_hs),
    .i_shift  (w_shift),
    .i_data   (data_in),
    .o_msb    (w_msb),
    .o_parity (w_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dout    <= IDLE_BIT;
      r_dout_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_hs) begin
            r_state   <= ST_SYNC;
            r_dout    <= SYNC[3];
            r_dout_en <= 1'b1;
          end else begin
            r_dout    <= IDLE_BIT;
            r_dout_en <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (r_cnt == SYNC_LAST) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_dout  <= w_msb;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_dout <= w_sync_next;
          end
        end
        ST_DATA: begin
          if (r_cnt == DATA_LAST) begin
            r_state <= ST_PARITY;
            r_cnt   <= '0;
            r_dout  <= w_par;
            r_done  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_dout <= w_msb;
          end
        end
        ST_PARITY: begin
          r_cnt <= '0;
          if (w_hs) begin
            r_state   <= ST_SYNC;
            r_dout    <= SYNC[3];
            r_dout_en <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_dout    <= IDLE_BIT;
            r_dout_en <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_dout    <= IDLE_BIT;
          r_dout_en <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = w_ready;
  assign dout       = r_dout;
  assign dout_en    = r_dout_en;
  assign frame_done = r_done;

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed self-checking bench for seq_tx (default parameters).
module tb_seq_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       dout;
  logic       dout_en;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seq_tx dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dout       (dout),
    .dout_en    (dout_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // falling-edge 1101/0110 detector on the serial line
  logic [3:0] det_sh = 4'b0000;
  logic       det_flag;
  int         cyc = 0;
  int         det_cnt = 0;
  int         det_prev = -1;
  int         det_last = -1;

  always @(negedge clk) det_sh <= {det_sh[2:0], dout};
  assign det_flag = (det_sh == 4'b1101) || (det_sh == 4'b0110);

  always @(posedge clk) begin
    if (det_flag) begin
      det_cnt  = det_cnt + 1;
      det_prev = det_last;
      det_last = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, " idle dout"}, 32'(dout), 32'(0));
    chk({name, " idle dout_en"}, 32'(dout_en), 32'(0));
    chk({name, " idle frame_done"}, 32'(frame_done), 32'(0));
    chk({name, " idle data_ready"}, 32'(data_ready), 32'(1));
  endtask

  // Walk one frame starting at the negedge after its handshake.
  // vmode: 0 drop valid, 1 hold valid (data_in scrambled), 2 toggle valid + scramble.
  // At the parity bit, valid is set to 'chain' and data_in to 'nxt'.
  task automatic run_frame(input string name, input logic [12:0] exp, input int vmode,
                           input bit chain, input logic [7:0] nxt);
    for (int i = 0; i < frame_len(8); i++) begin
      @(negedge clk);
      chk($sformatf("%s dout b%0d", name, i), 32'(dout), 32'(exp[12-i]));
      chk($sformatf("%s dout_en b%0d", name, i), 32'(dout_en), 32'(1));
      chk($sformatf("%s frame_done b%0d", name, i), 32'(frame_done), 32'(i == 12));
      chk($sformatf("%s data_ready b%0d", name, i), 32'(data_ready), 32'(i == 12));
      if (i == 12) begin
        data_valid = chain;
        data_in    = nxt;
      end else if (vmode == 0) begin
        data_valid = 1'b0;
      end else if (vmode == 2) begin
        data_valid = i[0];
        data_in    = 8'($urandom);
      end else begin
        data_in = 8'($urandom);
      end
    end
  endtask

  int c0;
  int s0;

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;

    @(negedge clk);
    chk("reset dout", 32'(dout), 32'(0));
    chk("reset dout_en", 32'(dout_en), 32'(0));
    chk("reset frame_done", 32'(frame_done), 32'(0));
    chk("reset data_ready", 32'(data_ready), 32'(0));
    rst = 1'b0;
    idle_chk("post_reset");

    // single frame 0xA5
    data_in = 8'hA5; data_valid = 1'b1;
    run_frame("a5", 13'b1101_10100101_0, 0, 1'b0, 8'h00);
    idle_chk("a5");

    // back-to-back 0x00 then 0xFF with valid held
    data_in = 8'h00; data_valid = 1'b1;
    run_frame("b2b_00", 13'b1101_00000000_0, 1, 1'b1, 8'hFF);
    run_frame("b2b_ff", 13'b1101_11111111_0, 1, 1'b0, 8'h00);
    idle_chk("b2b");

    // parity
    data_in = 8'h01; data_valid = 1'b1;
    run_frame("par01", 13'b1101_00000001_1, 0, 1'b0, 8'h00);
    idle_chk("par01");
    data_in = 8'h03; data_valid = 1'b1;
    run_frame("par03", 13'b1101_00000011_0, 0, 1'b0, 8'h00);
    idle_chk("par03");

    // stall: valid toggling and data_in scrambled while not ready
    data_in = 8'h96; data_valid = 1'b1;
    run_frame("stall96", 13'b1101_10010110_0, 2, 1'b0, 8'h00);
    idle_chk("stall96");

    // reset during payload bit 3 of 0xA5
    data_in = 8'hA5; data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      chk($sformatf("abort dout b%0d", i), 32'(dout), 32'(((13'b1101_10100101_0) >> (12 - i)) & 13'd1));
    end
    #2 rst = 1'b1;
    #1;
    chk("abort async dout", 32'(dout), 32'(0));
    chk("abort async dout_en", 32'(dout_en), 32'(0));
    chk("abort async frame_done", 32'(frame_done), 32'(0));
    chk("abort async data_ready", 32'(data_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    idle_chk("abort_1");
    idle_chk("abort_2");
    idle_chk("abort_3");
    data_in = 8'h3C; data_valid = 1'b1;
    run_frame("after_abort3c", 13'b1101_00111100_0, 0, 1'b0, 8'h00);
    idle_chk("after_abort");

    // loopback into the detector, payload 0x00 after idle line
    repeat (4) idle_chk("loop_pre");
    c0 = det_cnt;
    s0 = cyc;
    data_in = 8'h00; data_valid = 1'b1;
    run_frame("loop00", 13'b1101_00000000_0, 0, 1'b0, 8'h00);
    idle_chk("loop00");
    chk("loop det count", 32'(det_cnt - c0), 32'(2));
    chk("loop det after sync3", 32'(det_prev), 32'(s0 + 3));
    chk("loop det after sync4", 32'(det_last), 32'(s0 + 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
